// File: rtl/distributor.sv
// distributor: registered 1-to-OUT demultiplexer with per-lane valid/ready handshake,
// routing each accepted word to one lane (index mode) or several lanes (bitmap multicast).
module distributor #(
    parameter int DATA = 32,
    parameter int OUT = 4,
    parameter bit BIT_MAP = 1'b0,
    parameter bit ACT = 1'b1,
    parameter int SEL_WIDTH = BIT_MAP ? OUT : $clog2(OUT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA-1:0]      in,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [OUT-1:0]       out_valid,
    input  logic [OUT-1:0]       out_ready,
    output logic [DATA*OUT-1:0]  out,
    output logic                 drop,
    output logic                 busy
);
    logic [DATA-1:0] hold;
    logic [OUT-1:0]  pend;
    logic [OUT-1:0]  dest;
    logic [OUT-1:0]  clr;
    logic            acc;

    for (genvar i = 0; i < OUT; i++) begin : g_lane
        if (BIT_MAP) begin : g_map
            assign dest[i] = sel[i] == ACT;
        end else begin : g_idx
            assign dest[i] = sel == SEL_WIDTH'(i);
        end
        assign out[DATA*i +: DATA] = pend[i] ? hold : '0;
    end

    // A new word may enter only when every still-pending lane handshakes this cycle
    assign in_ready  = (pend & ~out_ready) == '0;
    assign acc       = in_valid && in_ready;
    assign clr       = pend & out_ready;
    assign out_valid = pend;
    assign busy      = |pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
            pend <= '0;
            drop <= 1'b0;
        end else begin
            hold <= acc ? in : hold;
            pend <= acc ? dest : (pend & ~clr);
            drop <= acc && (dest == '0);
        end
    end
endmodule

// File: tb/tb_distributor.sv
// tb_distributor: four distributor configurations driven from one stimulus stream and
// checked every cycle against a per-lane obligation model, plus directed vectors.
module tb_distributor;
    logic clk = 1'b0;
    logic reset;
    logic iv;
    logic [31:0] din;
    logic [3:0] sel;
    logic [3:0] ordy;

    logic ir_a, ir_b, ir_c, ir_d;
    logic dp_a, dp_b, dp_c, dp_d;
    logic bs_a, bs_b, bs_c, bs_d;
    logic [3:0] ov_a, ov_b, ov_c;
    logic [2:0] ov_d;
    logic [127:0] od_a, od_b, od_c;
    logic [95:0] od_d;

    logic ir[4], dp[4], bs[4];
    logic [3:0] ov[4];
    logic [127:0] od[4];

    logic [3:0] m_owed[4];
    logic [31:0] m_word[4];
    logic m_drop[4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    distributor #(.DATA(32), .OUT(4), .BIT_MAP(1'b0)) u_a (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir_a), .in(din), .sel(sel[1:0]),
        .out_valid(ov_a), .out_ready(ordy), .out(od_a), .drop(dp_a), .busy(bs_a));
    distributor #(.DATA(32), .OUT(4), .BIT_MAP(1'b1), .ACT(1'b1)) u_b (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir_b), .in(din), .sel(sel),
        .out_valid(ov_b), .out_ready(ordy), .out(od_b), .drop(dp_b), .busy(bs_b));
    distributor #(.DATA(32), .OUT(4), .BIT_MAP(1'b1), .ACT(1'b0)) u_c (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir_c), .in(din), .sel(sel),
        .out_valid(ov_c), .out_ready(ordy), .out(od_c), .drop(dp_c), .busy(bs_c));
    distributor #(.DATA(32), .OUT(3), .BIT_MAP(1'b0)) u_d (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir_d), .in(din), .sel(sel[1:0]),
        .out_valid(ov_d), .out_ready(ordy[2:0]), .out(od_d), .drop(dp_d), .busy(bs_d));

    always_comb begin
        ir = '{ir_a, ir_b, ir_c, ir_d};
        dp = '{dp_a, dp_b, dp_c, dp_d};
        bs = '{bs_a, bs_b, bs_c, bs_d};
        ov = '{ov_a, ov_b, ov_c, {1'b0, ov_d}};
        od = '{od_a, od_b, od_c, {32'h0, od_d}};
    end

    // k: 0 index/4 lanes, 1 bitmap active-high, 2 bitmap active-low, 3 index/3 lanes
    function automatic logic [3:0] dest_of(int k, logic [3:0] s);
        case (k)
            0: return 4'(1) << s[1:0];
            1: return s;
            2: return ~s;
            default: return (s[1:0] == 2'd3) ? 4'b0 : 4'(1) << s[1:0];
        endcase
    endfunction

    function automatic logic m_ready(int k);
        return (m_owed[k] & ~ordy) == 4'b0;
    endfunction

    task automatic chk(string nm, int k, logic [127:0] got, logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h", nm, k, got, want);
        end
    endtask

    task automatic settle();
        logic [127:0] e;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            e = '0;
            for (int i = 0; i < 4; i++) e[32*i +: 32] = m_owed[k][i] ? m_word[k] : 32'h0;
            chk("out_valid", k, 128'(ov[k]), 128'(m_owed[k]));
            chk("in_ready", k, 128'(ir[k]), 128'(m_ready(k)));
            chk("busy", k, 128'(bs[k]), 128'(m_owed[k] != 4'b0));
            chk("drop", k, 128'(dp[k]), 128'(m_drop[k]));
            chk("out", k, od[k], e);
        end
    endtask

    task automatic adv();
        logic a;
        logic [3:0] d;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                m_owed[k] = '0;
                m_word[k] = '0;
                m_drop[k] = 1'b0;
            end else begin
                a = iv && m_ready(k);
                d = dest_of(k, sel);
                m_drop[k] = a && d == 4'b0;
                if (a) begin
                    m_owed[k] = d;
                    m_word[k] = din;
                end else begin
                    m_owed[k] = m_owed[k] & ~ordy;
                end
            end
        end
        #1;
    endtask

    task automatic drv(logic r, logic v, logic [31:0] d, logic [3:0] s, logic [3:0] o);
        reset = r;
        iv = v;
        din = d;
        sel = s;
        ordy = o;
        settle();
    endtask

    typedef struct {
        logic v;
        logic [31:0] d;
        logic [3:0] s;
        logic [3:0] o;
        logic [3:0] eov;
        logic eir;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 32'd1,    4'd0, 4'hF, 4'b0000, 1'b1};
        tbl[1]  = '{1'b1, 32'd2,    4'd1, 4'hF, 4'b0001, 1'b1};
        tbl[2]  = '{1'b1, 32'd3,    4'd2, 4'hF, 4'b0010, 1'b1};
        tbl[3]  = '{1'b1, 32'd4,    4'd3, 4'hF, 4'b0100, 1'b1};
        tbl[4]  = '{1'b0, 32'd0,    4'd0, 4'hF, 4'b1000, 1'b1};
        tbl[5]  = '{1'b0, 32'd0,    4'd0, 4'h0, 4'b0000, 1'b1};
        tbl[6]  = '{1'b1, 32'hA5,   4'd2, 4'h0, 4'b0000, 1'b1};
        tbl[7]  = '{1'b0, 32'd0,    4'd0, 4'h0, 4'b0100, 1'b0};
        tbl[8]  = '{1'b1, 32'd9,    4'd0, 4'h0, 4'b0100, 1'b0};
        tbl[9]  = '{1'b0, 32'd0,    4'd0, 4'h4, 4'b0100, 1'b1};
        tbl[10] = '{1'b0, 32'd0,    4'd0, 4'h0, 4'b0000, 1'b1};

        reset = 1'b1; iv = 1'b0; din = '0; sel = '0; ordy = '0;
        adv();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
        chk("rst_in_ready", 0, 128'(ir[0]), 128'(1));
        adv();

        for (int n = 0; n < 11; n++) begin
            drv(1'b0, tbl[n].v, tbl[n].d, tbl[n].s, tbl[n].o);
            chk("tbl_ov", n, 128'(ov[0]), 128'(tbl[n].eov));
            chk("tbl_ir", n, 128'(ir[0]), 128'(tbl[n].eir));
            adv();
        end
        for (int n = 0; n < 2; n++) begin drv(1'b0, 1'b0, 32'h0, 4'h0, 4'hF); adv(); end

        // multicast with out-of-order lane release and a blocked second word
        drv(1'b0, 1'b1, 32'd7, 4'b1011, 4'b0000);
        chk("mc_ir0", 1, 128'(ir[1]), 128'(1));
        adv();
        drv(1'b0, 1'b1, 32'd8, 4'b0100, 4'b0000);
        chk("mc_ov0", 1, 128'(ov[1]), 128'(4'b1011));
        chk("mc_ir1", 1, 128'(ir[1]), 128'(0));
        adv();
        drv(1'b0, 1'b1, 32'd8, 4'b0100, 4'b1000);
        chk("mc_ov1", 1, 128'(ov[1]), 128'(4'b1011));
        chk("mc_ir2", 1, 128'(ir[1]), 128'(0));
        adv();
        drv(1'b0, 1'b1, 32'd8, 4'b0100, 4'b0001);
        chk("mc_ov2", 1, 128'(ov[1]), 128'(4'b0011));
        chk("mc_ir3", 1, 128'(ir[1]), 128'(0));
        adv();
        drv(1'b0, 1'b1, 32'd8, 4'b0100, 4'b0010);
        chk("mc_ov3", 1, 128'(ov[1]), 128'(4'b0010));
        chk("mc_ir4", 1, 128'(ir[1]), 128'(1));
        chk("mc_lane1", 1, 128'(od[1][63:32]), 128'(7));
        adv();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
        chk("mc_ov4", 1, 128'(ov[1]), 128'(4'b0100));
        chk("mc_lane2", 1, 128'(od[1][95:64]), 128'(8));
        adv();
        for (int n = 0; n < 2; n++) begin drv(1'b0, 1'b0, 32'h0, 4'h0, 4'hF); adv(); end

        // words with no legal destination
        drv(1'b0, 1'b1, 32'd5, 4'b0000, 4'hF);
        adv();
        drv(1'b0, 1'b1, 32'd6, 4'b0011, 4'hF);
        chk("drop_b", 1, 128'(dp[1]), 128'(1));
        chk("drop_b_ov", 1, 128'(ov[1]), 128'(0));
        chk("drop_b_ir", 1, 128'(ir[1]), 128'(1));
        adv();
        drv(1'b0, 1'b1, 32'd9, 4'b0001, 4'hF);
        chk("drop_b_clr", 1, 128'(dp[1]), 128'(0));
        chk("after_drop_b", 1, 128'(ov[1]), 128'(4'b0011));
        chk("drop_d", 3, 128'(dp[3]), 128'(1));
        chk("drop_d_ov", 3, 128'(ov[3]), 128'(0));
        adv();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 4'hF);
        chk("drop_d_clr", 3, 128'(dp[3]), 128'(0));
        chk("after_drop_d", 3, 128'(ov[3]), 128'(4'b0010));
        adv();

        // active-low bitmap
        drv(1'b0, 1'b1, 32'd3, 4'b1110, 4'hF);
        adv();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
        chk("act_low", 2, 128'(ov[2]), 128'(4'b0001));
        adv();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 4'hF);
        adv();

        // reset while a multicast word is pending
        drv(1'b0, 1'b1, 32'hC, 4'b1111, 4'h0);
        adv();
        drv(1'b1, 1'b0, 32'h0, 4'h0, 4'h0);
        chk("pre_rst_ov", 1, 128'(ov[1]), 128'(4'b1111));
        chk("pre_rst_busy", 1, 128'(bs[1]), 128'(1));
        adv();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
        chk("rst_ov", 1, 128'(ov[1]), 128'(0));
        chk("rst_out", 1, od[1], 128'(0));
        chk("rst_busy", 1, 128'(bs[1]), 128'(0));
        chk("rst_ir", 1, 128'(ir[1]), 128'(1));
        adv();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 4'hF);
        chk("rst_gone", 1, 128'(ov[1]), 128'(0));
        adv();

        for (int n = 0; n < 3000; n++) begin
            drv($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom,
                4'($urandom), 4'($urandom));
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
